// File: rtl/pipe_csa_addsub.sv
// pipe_csa_addsub: pipelined carry-select adder/subtractor.
// Each SEG-bit slice resolves in its own register stage. Operand slices are
// skewed through the pipe so that slice k meets the carry produced by slice k-1
// one cycle later. A valid/ready handshake with a global stall gives one
// result per cycle under backpressure.
module pipe_csa_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int L = WIDTH / SEG;

  if (WIDTH < 2 || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipe_csa_addsub: WIDTH must be >= 2 and an exact multiple of SEG");
  end

  // A result sitting at the output that is not being taken freezes every stage.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int SW = WIDTH - k * SEG;  // operand bits not yet resolved on entry to stage k
    localparam int RW = (k + 1) * SEG;    // sum bits resolved once stage k is loaded

    logic [SW-1:0] src_a;
    logic [SW-1:0] src_bb;
    logic          src_c;
    logic          src_v;
    logic [SEG:0]  cand0;
    logic [SEG:0]  cand1;
    logic [SEG:0]  pick;
    logic [RW-1:0] sum_d;
    logic [RW-1:0] sum_q;
    logic          carry_d;
    logic          carry_q;
    logic          valid_d;
    logic          valid_q;

    if (k == 0) begin : g_head
      // Stage 0 folds the subtract into an add: invert b, invert the carry-in.
      assign src_a  = a;
      assign src_bb = b ^ {WIDTH{sub}};
      assign src_c  = ci ^ sub;
      assign src_v  = in_valid;
      assign sum_d  = pick[SEG-1:0];
    end else begin : g_body
      assign src_a  = g_stage[k-1].g_fwd.a_q;
      assign src_bb = g_stage[k-1].g_fwd.bb_q;
      assign src_c  = g_stage[k-1].carry_q;
      assign src_v  = g_stage[k-1].valid_q;
      assign sum_d  = {pick[SEG-1:0], g_stage[k-1].sum_q};
    end

    // Carry-select slice: both candidate sums in parallel, picked by the incoming carry.
    // NOTE: every variable is assigned on every pass through always_comb, so no latch is inferred.
    always_comb begin
      cand0   = {1'b0, src_a[SEG-1:0]} + {1'b0, src_bb[SEG-1:0]};
      cand1   = {1'b0, src_a[SEG-1:0]} + {1'b0, src_bb[SEG-1:0]} + {{SEG{1'b0}}, 1'b1};
      pick    = src_c ? cand1 : cand0;
      carry_d = pick[SEG];
      valid_d = src_v;
    end

    // Stage control and resolved low sum bits; everything holds while stalled.
    // NOTE: non-blocking assignments so all stages sample the pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (!stall) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    if (k < L - 1) begin : g_fwd
      logic [SW-SEG-1:0] a_d;
      logic [SW-SEG-1:0] a_q;
      logic [SW-SEG-1:0] bb_d;
      logic [SW-SEG-1:0] bb_q;

      // Upper operand slices (including the MSBs overflow needs) ride along unresolved.
      always_comb begin
        a_d  = src_a[SW-1:SEG];
        bb_d = src_bb[SW-1:SEG];
      end

      // Skew registers for the upper operand slices.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bb_q <= '0;
        end else if (!stall) begin
          a_q  <= a_d;
          bb_q <= bb_d;
        end
      end
    end else begin : g_tail
      logic ovf_d;
      logic ovf_q;

      // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
      always_comb begin
        ovf_d = (src_a[SW-1] == src_bb[SW-1]) && (sum_d[RW-1] != src_a[SW-1]);
      end

      // Overflow flag registered alongside the final sum slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign sum       = g_stage[L-1].sum_q;
  assign co        = g_stage[L-1].carry_q;
  assign out_valid = g_stage[L-1].valid_q;
  assign ovf       = g_stage[L-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_csa_addsub.sv
// Bench for pipe_csa_addsub: a 16/4 instance for directed vectors, backpressure,
// bubbles and mid-stream reset, and a 4/2 instance for an exhaustive sweep.
module tb_pipe_csa_addsub;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int L  = W / S;
  localparam int W4 = 4;
  localparam int S4 = 2;
  localparam int L4 = W4 / S4;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vci;
    logic        vsub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out16 = 0;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, sum;
  logic          ci, sub, co, ovf;

  logic          in_valid4, in_ready4, out_valid4, out_ready4;
  logic [W4-1:0] a4, b4, sum4;
  logic          ci4, sub4, co4, ovf4;

  exp_t q16[$];
  exp_t q4[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipe_csa_addsub #(.WIDTH(W), .SEG(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf)
  );

  pipe_csa_addsub #(.WIDTH(W4), .SEG(S4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .ci(ci4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .co(co4), .ovf(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an unexpected or missing event", name);
  endtask

  // Arithmetic reference: plain integer add/subtract, signed range test for overflow.
  function automatic exp_t model(input int w, input logic [15:0] a_i, input logic [15:0] b_i,
                                 input logic ci_i, input logic sub_i);
    exp_t   e;
    longint m, h, ua, ub, sa, sb, cv, r, sr;
    m  = longint'(1) << w;
    h  = m >> 1;
    ua = longint'(a_i);
    ub = longint'(b_i);
    cv = ci_i ? 1 : 0;
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    if (!sub_i) begin
      r    = ua + ub + cv;
      e.co = (r >= m);
      sr   = sa + sb + cv;
    end else begin
      r    = ua - ub - cv;
      e.co = (ua >= ub + cv);
      sr   = sa - sb - cv;
    end
    e.sum = 16'(r & (m - 1));
    e.ovf = (sr < -h) || (sr >= h);
    e.acc = 0;
    return e;
  endfunction

  // One cycle on the 16-bit DUT: drive, score any output transfer, record any input transfer.
  task automatic step16(input logic v, input logic [15:0] a_i, input logic [15:0] b_i,
                        input logic ci_i, input logic sub_i, input logic ordy,
                        output logic acc, output logic rdy);
    exp_t e;
    in_valid  = v;
    a         = a_i;
    b         = b_i;
    ci        = ci_i;
    sub       = sub_i;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      if (q16.size() == 0) begin
        fail("s16_spurious_out");
      end else begin
        e = q16.pop_front();
        check("s16_sum", sum, e.sum);
        check("s16_co", co, e.co);
        check("s16_ovf", ovf, e.ovf);
        n_out16++;
      end
    end
    if (acc) q16.push_back(model(W, a_i, b_i, ci_i, sub_i));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, rdy, ordy, v;
    logic [15:0] hs;
    logic        hc, ho;
    logic        pat[16];
    exp_t        e;
    int          sent, t, idx, guard;

    //                 a         b         ci    sub   sum       co    ovf
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[2]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    tbl[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[7]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[8]  = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{16'h5555, 16'hAAAA, 1'b0, 1'b1, 16'hAAAB, 1'b0, 1'b1};
    tbl[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_co", co, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid4", out_valid4, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with exact latency
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; a = tbl[i].va; b = tbl[i].vb; ci = tbl[i].vci; sub = tbl[i].vsub;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (L - 2) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("vec%0d_early_valid", i), out_valid, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_sum", i), sum, tbl[i].es);
      check($sformatf("vec%0d_co", i), co, tbl[i].ec);
      check($sformatf("vec%0d_ovf", i), ovf, tbl[i].eo);
    end

    // Exhaustive 4-bit sweep, back to back, with latency check
    idx = 0;
    guard = 0;
    while ((idx < 1024 || q4.size() > 0) && guard < 3000) begin
      {a4, b4, ci4, sub4} = idx[9:0];
      in_valid4  = (idx < 1024);
      out_ready4 = 1'b1;
      #1;
      if (out_valid4) begin
        if (q4.size() == 0) begin
          fail("x4_spurious_out");
        end else begin
          e = q4.pop_front();
          check("x4_co_sum", {co4, sum4}, {e.co, e.sum[3:0]});
          check("x4_ovf", ovf4, e.ovf);
          check("x4_latency", cyc - e.acc, L4 - 1);
        end
      end
      if (in_valid4 && in_ready4) begin
        e = model(W4, {12'h000, a4}, {12'h000, b4}, ci4, sub4);
        e.acc = cyc + 1;
        q4.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) fail("x4_timeout");
    in_valid4 = 1'b0;
    @(posedge clk);
    #1;
    check("x4_drained", out_valid4, 1'b0);

    // Backpressure: 10 ops, out_ready low for 3 cycles mid-stream
    q16.delete();
    n_out16 = 0;
    sent = 0;
    t = 0;
    while ((sent < 10 || q16.size() > 0) && t < 60) begin
      ordy = !(t >= 6 && t < 9);
      if (t == 6) begin
        hs = sum; hc = co; ho = ovf;
        check("bp_valid_at_hold", out_valid, 1'b1);
      end
      if (t >= 7 && t <= 9) begin
        check("bp_frozen_valid", out_valid, 1'b1);
        check("bp_frozen_sum", sum, hs);
        check("bp_frozen_co", co, hc);
        check("bp_frozen_ovf", ovf, ho);
      end
      step16(sent < 10, 16'(sent * 16'h1111 + 16'h0123), 16'(sent * 16'h0F0F),
             sent[0], sent[1], ordy, acc, rdy);
      if (t >= 6 && t < 9) check("bp_in_ready_low", rdy, 1'b0);
      if (acc) sent++;
      t++;
    end
    if (t >= 60) fail("bp_timeout");
    check("bp_result_count", n_out16, 10);

    // Bubbles: alternating in_valid reappears on out_valid L cycles later
    for (int i = 0; i < 16; i++) pat[i] = 1'b0;
    for (int k = 0; k < 8 + L; k++) begin
      if (k >= L) check($sformatf("bub_valid_t%0d", k), out_valid, pat[k-L]);
      v = (k < 8) && (k % 2 == 0);
      pat[k] = v;
      step16(v, 16'(16'h0100 * k + 16'h0007), 16'h0011, 1'b0, 1'b0, 1'b1, acc, rdy);
    end
    check("bub_queue_empty", q16.size(), 0);

    // Reset with ops in flight
    for (int i = 0; i < 5; i++) begin
      step16(1'b1, 16'(16'h1001 + i), 16'h0101, 1'b0, 1'b0, 1'b1, acc, rdy);
    end
    check("mid_pre_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_co", co, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    q16.delete();
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 1; j < L; j++) begin
      check($sformatf("mid_no_stale_%0d", j), out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    check("mid_new_valid", out_valid, 1'b1);
    check("mid_new_sum", sum, 16'h1235);
    check("mid_new_co", co, 1'b0);
    check("mid_new_ovf", ovf, 1'b0);
    @(posedge clk);
    #1;
    check("mid_after_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
